bist_response_checker: RTL and testbench
========================================

Name: bist_response_checker

Overview:
Observer-side counterpart to the BIST controller. It watches the controller's run_in, out_in and bist_end_in strobes and checks the segment protocol: N_LEN cycles of out_in high, then a one-cycle gap, repeated M_SEGS times. While out_in is high it compacts the circuit-under-test response into a MISR signature. When the run ends it reports pass/fail and an error code to the top-level test harness.

Parameters:
N_LEN, 8, expected out_in-high cycles per segment (must be ≥1)
M_SEGS, 13, expected segments per BIST run (counter M 0..12)
DATA_W, 8, width of cut_data and MISR
POLY, 8'hB8, MISR feedback polynomial taps
GOLDEN, 8'hA5, expected final signature
CNT_W, 8, width of the length and segment counters (must hold N_LEN+1 and M_SEGS+1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
run_in  in  1  controller Running strobe
out_in  in  1  controller OUT strobe
bist_end_in  in  1  controller BIST_END strobe
cut_data  in  DATA_W  circuit-under-test response, sampled when out_in=1
done  out  1  result valid; held until next run or reset
pass  out  1  run matched protocol and signature
fail  out  1  protocol or signature error
err_code  out  2  0 none, 1 segment length, 2 segment count/gap, 3 signature
signature  out  DATA_W  current MISR value
seg_count  out  CNT_W  completed segments in the current run

Behaviour:
- All outputs registered. Reset: state WAIT; done, pass, fail = 0; err_code = 0; signature = 0; seg_count = 0; internal len = 0. Reset wins over every other event, including mid-run.
- MISR update, for every cycle with out_in=1 in WAIT(start)/GAP(restart)/HIGH: sig <= {sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? POLY : 0) ^ cut_data.
- WAIT: hold. If run_in=1 & out_in=1: clear sig to 0 then absorb cut_data, len=1, seg_count=0 → HIGH.
- HIGH, out_in=1: len++ and MISR update. If len would reach N_LEN+1: fail, err_code=1 → DONE.
- HIGH, out_in=0: len must equal N_LEN, else fail with err_code=1. Otherwise seg_count++.
  - If bist_end_in=1 in the same cycle → CHECK.
  - Else if run_in=1 → GAP.
  - Else fail, err_code=2.
- GAP, exactly one cycle:
  - out_in=1 & run_in=1 → HIGH with len=1 and MISR update.
  - out_in=0 & bist_end_in=1 → CHECK.
  - Anything else (second gap cycle, run_in drop) → fail, err_code=2.
- CHECK, one cycle:
  - seg_count ≠ M_SEGS → fail, err_code=2.
  - Else sig ≠ GOLDEN → fail, err_code=3.
  - Else pass.
  - done=1 in all cases → DONE.
- Latency: bist_end_in sampled at edge k → done/pass/fail visible after edge k+1.
- DONE: hold done, pass, fail, err_code, signature, seg_count. A new start (run_in=1 & out_in=1) clears done, pass, fail and err_code and restarts as from WAIT in that same cycle. While in DONE, bist_end_in held high is ignored.
- Simultaneous events:
  - bist_end_in=1 while out_in=1 in HIGH: length error takes priority if the length is wrong; else treat as a final segment that ends with no gap cycle.
  - pass and fail are never both 1.
- seg_count saturates at 2^CNT_W-1, so no wrap-around occurs.

Decomposition:
- Shared package bist_pkg holds the state encodings (WAIT, HIGH, GAP, CHECK, DONE) and the err_code constants (ERR_NONE, ERR_LEN, ERR_SEG, ERR_SIG).
- One sub-module, bist_misr (DATA_W, POLY; ports clk, reset, clr, en, din, sig), instantiated once.
- The FSM and counters stay in bist_response_checker.

Test Plan:
1. Nominal run: N_LEN=8, 13 segments with one-cycle gaps, bist_end_in on the last falling out_in, cut_data chosen so the final signature equals GOLDEN → done=1, pass=1, err_code=0, seg_count=13, two edges after bist_end_in.
2. Short segment: segment 3 has out_in high for 7 cycles → fail=1, err_code=1, seg_count=2.
3. Long segment: out_in high for 9 cycles → fail asserted on the 9th high cycle, err_code=1.
4. Segment-count and gap errors: bist_end_in after only 12 segments → fail, err_code=2. Separately, a two-cycle gap → fail, err_code=2.
5. Signature mismatch: nominal timing with cut_data flipped in one cycle → fail=1, err_code=3, signature ≠ 8'hA5.
6. Reset and restart: reset at segment 5 → all outputs 0 on the next edge and state WAIT. Then a fresh nominal run → pass. After DONE, a new start clears done and the second run passes.

Source files
------------

// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST response checker slice: the checker FSM
// state encoding and the error codes reported on err_code.
// No ports (package).
// ---------------------------------------------------------------------------
package bist_pkg;

   // Checker FSM states. WAIT is idle before the first run; DONE holds a result.
   typedef enum logic [2:0] {
      WAIT  = 3'd0,
      HIGH  = 3'd1,
      GAP   = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } bistStateT;

   // Error codes reported alongside fail.
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_SEG  = 2'd2;
   localparam logic [1:0] ERR_SIG  = 2'd3;

endpackage

// File: rtl/bist_misr.sv
// ---------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register that compacts the circuit-under-test
// response into a DATA_W-bit signature using a Galois-style shift with POLY
// feedback taps.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, clears the signature
//   clr   - start a fresh signature (treated as zero) in the same update
//   en    - absorb din this cycle
//   din   - response word to absorb
//   sig   - current signature (registered)
// ---------------------------------------------------------------------------
module bist_misr
   import bist_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] POLY   = 8'hB8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sig
);

   logic [DATA_W-1:0] r_sig;
   logic [DATA_W-1:0] w_base;
   logic [DATA_W-1:0] w_next;

   // Next signature: shift left, fold the outgoing MSB back through the taps,
   // then mix in the new word. A clear restarts from zero so the first word
   // of a run is absorbed in the same cycle.
   always_comb begin
      w_base = clr ? '0 : r_sig;
      w_next = {w_base[DATA_W-2:0], 1'b0} ^ (w_base[DATA_W-1] ? POLY : '0) ^ din;
   end

   // Signature register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sig <= '0;
      end else if (en) begin
         r_sig <= w_next;
      end
   end

   assign sig = r_sig;

endmodule

// File: rtl/bist_response_checker.sv
// ---------------------------------------------------------------------------
// bist_response_checker
// Observes the BIST controller strobes, checks the segment protocol
// (N_LEN high cycles, one gap cycle, M_SEGS segments), compacts the CUT
// response into a MISR and reports pass/fail with an error code.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   run_in       - controller Running strobe
//   out_in       - controller OUT strobe (response valid)
//   bist_end_in  - controller BIST_END strobe
//   cut_data     - CUT response, sampled while out_in=1
//   done         - result valid, held until next run or reset
//   pass / fail  - run verdict (never both high)
//   err_code     - 0 none, 1 segment length, 2 count/gap, 3 signature
//   signature    - current MISR value
//   seg_count    - completed segments in the current run (saturating)
// ---------------------------------------------------------------------------
module bist_response_checker
   import bist_pkg::*;
#(
   parameter int                N_LEN  = 8,
   parameter int                M_SEGS = 13,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] POLY   = 8'hB8,
   parameter logic [DATA_W-1:0] GOLDEN = 8'hA5,
   parameter int                CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_in,
   input  logic              out_in,
   input  logic              bist_end_in,
   input  logic [DATA_W-1:0] cut_data,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [1:0]        err_code,
   output logic [DATA_W-1:0] signature,
   output logic [CNT_W-1:0]  seg_count
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LEN_FULL  = CNT_W'(N_LEN);
   localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(N_LEN - 1);
   localparam logic [CNT_W-1:0] SEG_TOTAL = CNT_W'(M_SEGS);
   localparam logic [CNT_W-1:0] SEG_MAX   = '1;

   bistStateT         r_state;
   logic [CNT_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_segCount;
   logic              r_done;
   logic              r_pass;
   logic              r_fail;
   logic [1:0]        r_errCode;

   bistStateT         w_stateNext;
   logic [CNT_W-1:0]  w_lenNext;
   logic [CNT_W-1:0]  w_segNext;
   logic [CNT_W-1:0]  w_segInc;
   logic              w_doneNext;
   logic              w_passNext;
   logic              w_failNext;
   logic [1:0]        w_errNext;
   logic              w_raise;
   logic [1:0]        w_raiseCode;
   logic              w_start;
   logic              w_misrClr;
   logic              w_misrEn;
   logic [DATA_W-1:0] w_sig;

   assign w_start  = run_in & out_in;
   assign w_segInc = (r_segCount == SEG_MAX) ? r_segCount : r_segCount + ONE;

   bist_misr #(
      .DATA_W (DATA_W),
      .POLY   (POLY)
   ) u_misr (
      .clk   (clk),
      .reset (reset),
      .clr   (w_misrClr),
      .en    (w_misrEn),
      .din   (cut_data),
      .sig   (w_sig)
   );

   // Next-state and next-output logic. Protocol violations only raise a flag
   // and a code inside the case; the common error handling (latch fail, code
   // and done, park in DONE) is applied once after it.
   always_comb begin
      w_stateNext = r_state;
      w_lenNext   = r_len;
      w_segNext   = r_segCount;
      w_doneNext  = r_done;
      w_passNext  = r_pass;
      w_failNext  = r_fail;
      w_errNext   = r_errCode;
      w_raise     = 1'b0;
      w_raiseCode = ERR_NONE;
      w_misrClr   = 1'b0;
      w_misrEn    = 1'b0;

      unique case (r_state)
         WAIT, DONE: begin
            if (w_start) begin
               w_stateNext = HIGH;
               w_lenNext   = ONE;
               w_segNext   = '0;
               w_doneNext  = 1'b0;
               w_passNext  = 1'b0;
               w_failNext  = 1'b0;
               w_errNext   = ERR_NONE;
               w_misrClr   = 1'b1;
               w_misrEn    = 1'b1;
            end
         end

         HIGH: begin
            if (out_in) begin
               w_misrEn  = 1'b1;
               w_lenNext = r_len + ONE;
               if (r_len == LEN_FULL) begin
                  w_raise     = 1'b1;
                  w_raiseCode = ERR_LEN;
               end else if (bist_end_in) begin
                  // End strobe on a high cycle closes the final segment
                  // without a gap, provided this is its last high cycle.
                  if (r_len == LEN_LAST) begin
                     w_segNext   = w_segInc;
                     w_stateNext = CHECK;
                  end else begin
                     w_raise     = 1'b1;
                     w_raiseCode = ERR_LEN;
                  end
               end
            end else if (r_len != LEN_FULL) begin
               w_raise     = 1'b1;
               w_raiseCode = ERR_LEN;
            end else begin
               w_segNext = w_segInc;
               if (bist_end_in) begin
                  w_stateNext = CHECK;
               end else if (run_in) begin
                  w_stateNext = GAP;
               end else begin
                  w_raise     = 1'b1;
                  w_raiseCode = ERR_SEG;
               end
            end
         end

         GAP: begin
            if (out_in && run_in) begin
               w_stateNext = HIGH;
               w_lenNext   = ONE;
               w_misrEn    = 1'b1;
            end else if (!out_in && bist_end_in) begin
               w_stateNext = CHECK;
            end else begin
               w_raise     = 1'b1;
               w_raiseCode = ERR_SEG;
            end
         end

         CHECK: begin
            w_stateNext = DONE;
            w_doneNext  = 1'b1;
            if (r_segCount != SEG_TOTAL) begin
               w_raise     = 1'b1;
               w_raiseCode = ERR_SEG;
            end else if (w_sig != GOLDEN) begin
               w_raise     = 1'b1;
               w_raiseCode = ERR_SIG;
            end else begin
               w_passNext = 1'b1;
            end
         end

         default: begin
            w_stateNext = WAIT;
         end
      endcase

      if (w_raise) begin
         w_stateNext = DONE;
         w_doneNext  = 1'b1;
         w_passNext  = 1'b0;
         w_failNext  = 1'b1;
         w_errNext   = w_raiseCode;
      end
   end

   // State, counter and result registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= WAIT;
         r_len      <= '0;
         r_segCount <= '0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_errCode  <= ERR_NONE;
      end else begin
         r_state    <= w_stateNext;
         r_len      <= w_lenNext;
         r_segCount <= w_segNext;
         r_done     <= w_doneNext;
         r_pass     <= w_passNext;
         r_fail     <= w_failNext;
         r_errCode  <= w_errNext;
      end
   end

   assign done      = r_done;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign err_code  = r_errCode;
   assign signature = w_sig;
   assign seg_count = r_segCount;

endmodule

// File: tb/tb_bist_response_checker.sv
// ---------------------------------------------------------------------------
// tb_bist_response_checker
// Directed testbench for bist_response_checker. Runs are built from 8-cycle
// segments whose response data is zero except the last two words, so the
// final signature can be worked out by hand (zero stays zero through the
// MISR; a lone word W as the final input yields W).
// ---------------------------------------------------------------------------
module tb_bist_response_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       run_in;
   logic       out_in;
   logic       bist_end_in;
   logic [7:0] cut_data;
   logic       done;
   logic       pass;
   logic       fail;
   logic [1:0] err_code;
   logic [7:0] signature;
   logic [7:0] seg_count;

   int checkCount = 0;
   int passCount  = 0;

   bist_response_checker dut (
      .clk         (clk),
      .reset       (reset),
      .run_in      (run_in),
      .out_in      (out_in),
      .bist_end_in (bist_end_in),
      .cut_data    (cut_data),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .err_code    (err_code),
      .signature   (signature),
      .seg_count   (seg_count)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then settle just after the sampling edge.
   task automatic applyStimulus(input logic run, input logic out,
                                input logic endv, input logic [7:0] data);
      run_in      = run;
      out_in      = out;
      bist_end_in = endv;
      cut_data    = data;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One segment of len high cycles. endMode: 0 = falling cycle with run high
   // (gap follows), 1 = falling cycle with bist_end, 2 = bist_end on the last
   // high cycle and no falling cycle.
   task automatic driveSegment(input int len, input logic [7:0] dPen,
                               input logic [7:0] dLast, input int endMode);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = (i == len - 1) ? dLast : ((i == len - 2) ? dPen : 8'h00);
         applyStimulus(1'b1, 1'b1, (endMode == 2) && (i == len - 1), d);
      end
      if (endMode != 2) begin
         applyStimulus(1'b1, 1'b0, endMode == 1, 8'h00);
      end
   endtask

   // nSegs nominal segments; the special data and end mode apply to the last.
   task automatic runSegments(input int nSegs, input logic [7:0] dPen,
                              input logic [7:0] dLast, input int lastMode);
      for (int s = 1; s <= nSegs; s++) begin
         if (s == nSegs) begin
            driveSegment(8, dPen, dLast, lastMode);
         end else begin
            driveSegment(8, 8'h00, 8'h00, 0);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_pass", 32'(pass), 32'h0);
      checkOutput("rst_fail", 32'(fail), 32'h0);
      checkOutput("rst_err", 32'(err_code), 32'h0);
      checkOutput("rst_sig", 32'(signature), 32'h0);
      checkOutput("rst_seg", 32'(seg_count), 32'h0);
      reset = 1'b0;

      // WAIT ignores out_in without run_in.
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
      checkOutput("wait_hold_sig", 32'(signature), 32'h0);

      // Nominal run, end strobe on the last falling cycle.
      runSegments(13, 8'h00, 8'hA5, 1);
      checkOutput("nom_latency_done", 32'(done), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("nom_done", 32'(done), 32'h1);
      checkOutput("nom_pass", 32'(pass), 32'h1);
      checkOutput("nom_fail", 32'(fail), 32'h0);
      checkOutput("nom_err", 32'(err_code), 32'h0);
      checkOutput("nom_seg", 32'(seg_count), 32'd13);
      checkOutput("nom_sig", 32'(signature), 32'hA5);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("nom_hold_done", 32'(done), 32'h1);
      checkOutput("nom_hold_pass", 32'(pass), 32'h1);

      // Restart from DONE; final segment ends on its last high cycle.
      driveSegment(8, 8'h00, 8'h00, 0);
      checkOutput("restart_done_clr", 32'(done), 32'h0);
      checkOutput("restart_pass_clr", 32'(pass), 32'h0);
      checkOutput("restart_seg", 32'(seg_count), 32'd1);
      runSegments(12, 8'h00, 8'hA5, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("nogap_end_pass", 32'(pass), 32'h1);
      checkOutput("nogap_end_seg", 32'(seg_count), 32'd13);
      checkOutput("nogap_end_sig", 32'(signature), 32'hA5);

      // Short third segment (7 high cycles).
      runSegments(2, 8'h00, 8'h00, 0);
      driveSegment(7, 8'h00, 8'h00, 0);
      checkOutput("short_fail", 32'(fail), 32'h1);
      checkOutput("short_pass", 32'(pass), 32'h0);
      checkOutput("short_err", 32'(err_code), 32'h1);
      checkOutput("short_seg", 32'(seg_count), 32'd2);

      // Long segment: fail appears on the 9th high cycle.
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("long_fail_clr", 32'(fail), 32'h0);
      checkOutput("long_err_clr", 32'(err_code), 32'h0);
      for (int i = 2; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      end
      checkOutput("long_8_ok", 32'(fail), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("long_9_fail", 32'(fail), 32'h1);
      checkOutput("long_9_err", 32'(err_code), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

      // Only 12 segments before the end strobe.
      runSegments(12, 8'h00, 8'hA5, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("cnt12_fail", 32'(fail), 32'h1);
      checkOutput("cnt12_err", 32'(err_code), 32'h2);
      checkOutput("cnt12_seg", 32'(seg_count), 32'd12);

      // Two-cycle gap.
      driveSegment(8, 8'h00, 8'h00, 0);
      checkOutput("gap1_ok", 32'(fail), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("gap2_fail", 32'(fail), 32'h1);
      checkOutput("gap2_err", 32'(err_code), 32'h2);
      checkOutput("gap2_seg", 32'(seg_count), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

      // Signature mismatch: 0x80 then 0xA5 gives 0x00^0xB8^0xA5 = 0x1D.
      runSegments(13, 8'h80, 8'hA5, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("sig_fail", 32'(fail), 32'h1);
      checkOutput("sig_pass", 32'(pass), 32'h0);
      checkOutput("sig_err", 32'(err_code), 32'h3);
      checkOutput("sig_value", 32'(signature), 32'h1D);
      checkOutput("sig_seg", 32'(seg_count), 32'd13);

      // Reset in segment 5: 0x33 x3 gives 0x33, 0x55, 0x99.
      runSegments(4, 8'h00, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
      end
      checkOutput("mid_seg", 32'(seg_count), 32'd4);
      checkOutput("mid_sig", 32'(signature), 32'h99);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
      reset = 1'b0;
      checkOutput("midrst_done", 32'(done), 32'h0);
      checkOutput("midrst_fail", 32'(fail), 32'h0);
      checkOutput("midrst_err", 32'(err_code), 32'h0);
      checkOutput("midrst_sig", 32'(signature), 32'h0);
      checkOutput("midrst_seg", 32'(seg_count), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
      checkOutput("midrst_wait_sig", 32'(signature), 32'h0);

      // Fresh run after reset; end strobe arrives in the gap cycle.
      runSegments(13, 8'h00, 8'hA5, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("fresh_done", 32'(done), 32'h1);
      checkOutput("fresh_pass", 32'(pass), 32'h1);
      checkOutput("fresh_fail", 32'(fail), 32'h0);
      checkOutput("fresh_seg", 32'(seg_count), 32'd13);
      checkOutput("fresh_sig", 32'(signature), 32'hA5);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
